frame_mem_responder: RTL and testbench
======================================

FRAME_MEM_RESPONDER -- requirements
Module: frame_mem_responder

Interface
REQ-001 SHALL have parameters: SRC_W 320 (source width); SRC_H 240 (source height); DST_W 260 (destination width); DST_H 260 (destination height).
REQ-002 SHALL have one clock; reset is asynchronous and active-low: clk input 1 (rising-edge clock), rstn input 1 (async active-low reset).
REQ-003 SHALL have input stream ports: in_valid input 1, in_ready output 1, in_data input 8 (source pixels, raster order).
REQ-004 SHALL have reshaper-facing read ports: rd_en input 1, rd_addr input 20 (row*SRC_W+col), rd_data output 8.
REQ-005 SHALL have reshaper-facing write ports: wr_en input 1, wr_addr input 20 (row*DST_W+col), wr_data input 8 (lags wr_en by one cycle).
REQ-006 SHALL have control/status ports: ena output 1 (reshaper start), busy output 1, frame_done output 1, err output 1.
REQ-007 SHALL have output stream ports: out_valid output 1, out_ready input 1, out_data output 8 (destination pixels, raster order).

Function
REQ-008 SHALL hold a source memory of SRC_W*SRC_H bytes and a destination memory of DST_W*DST_H bytes.
REQ-009 SHALL implement states IDLE, LOAD, RUN, DRAIN.
REQ-010 IDLE: in_ready=1; first in_valid&in_ready writes pixel 0 and moves to LOAD.
REQ-011 LOAD: in_ready=1; each handshake writes in_data at the load pointer, then increments it; at the SRC_W*SRC_H-th pixel, in_ready drops next cycle and the state moves to RUN.
REQ-012 ena SHALL pulse high exactly one cycle, on the first RUN cycle; ena=0 in all other cycles.
REQ-013 Read port: rd_data SHALL be the source byte at rd_addr registered one cycle after rd_en=1 and SHALL hold its value while rd_en=0.
REQ-014 Write port, RUN only: wr_en=1 latches wr_addr; wr_data on the next cycle SHALL be committed to that address.
REQ-015 wr_en on consecutive cycles SHALL commit every write with no loss.
REQ-016 wr_en outside RUN SHALL be ignored; reads outside RUN still return data.
REQ-017 RUN SHALL count committed writes and move to DRAIN in the cycle after the DST_W*DST_H-th commit.
REQ-018 DRAIN: destination memory SHALL stream out in address order 0..DST_W*DST_H-1.
REQ-019 DRAIN: out_valid SHALL rise within 2 cycles of entry and sustain 1 pixel/cycle while out_ready=1.
REQ-020 DRAIN: out_data/out_valid SHALL hold stable while out_valid&~out_ready.
REQ-021 DRAIN: when the last pixel is accepted, frame_done SHALL pulse one cycle and the state SHALL return to IDLE.
REQ-022 busy SHALL be 1 in LOAD, RUN, DRAIN and 0 in IDLE.
REQ-023 All counters SHALL be 17-bit; they clear on state entry and do not wrap within a frame.

Reset
REQ-024 While rstn=0: state IDLE; in_ready=0; ena, busy, frame_done, out_valid, err = 0; rd_data=0; out_data=0; all counters and the pending-write flag cleared; memory contents not cleared.
REQ-025 Reset asserted mid-RUN SHALL discard any pending write; after release, operation restarts from IDLE.
REQ-026 in_ready SHALL go to 1 on the first clock edge after rstn release.

Configuration
REQ-027 Macro FRAME_MEM_RANGE_CHK_EN defined: rd_addr>=SRC_W*SRC_H returns rd_data=0, and wr_addr>=DST_W*DST_H drops the write without counting it; either case sets err sticky until reset.
REQ-028 Macro FRAME_MEM_RANGE_CHK_EN undefined: no address checks, err tied 0, out-of-range read data undefined, out-of-range writes undefined but counted.

Verification
REQ-029 Reset, then 76800 pixels data=addr[7:0] with in_valid held 1 -> ena single pulse on cycle after last accept; busy=1.
REQ-030 RUN, rd_en=1 rd_addr=321 -> rd_data=0x41 next cycle; rd_en=0 next -> rd_data stays 0x41.
REQ-031 RUN, wr_en=1 wr_addr=5 then wr_en=1 wr_addr=6 with wr_data 0xAA,0xBB on following cycles -> drain shows out_data 0xAA at index 5, 0xBB at 6.
REQ-032 After 67600 writes, out_ready toggled 1/0 each cycle -> 67600 pixels in order, no duplicates, frame_done one pulse, busy=0 after.
REQ-033 rstn low for 1 cycle mid-RUN after wr_en -> pending write not committed; in_ready=1 first cycle after release.
REQ-034 With FRAME_MEM_RANGE_CHK_EN, rd_addr=76800 -> rd_data=0, err=1 held until reset; without the macro, err stays 0.

Source files
------------

// File: rtl/frame_mem_responder.sv
// Frame buffer between a pixel stream and a reshaper: load source frame, serve reshaper reads/writes, drain destination frame.
// Optional macro FRAME_MEM_RANGE_CHK_EN adds address range checks and a sticky err flag.
module frame_mem_responder #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240,
  parameter int DST_W = 260,
  parameter int DST_H = 260
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        rd_en,
  input  logic [19:0] rd_addr,
  output logic [7:0]  rd_data,
  input  logic        wr_en,
  input  logic [19:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        ena,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  localparam int SRC_N = SRC_W * SRC_H;
  localparam int DST_N = DST_W * DST_H;
  localparam int SA = $clog2(SRC_N);
  localparam int DA = $clog2(DST_N);
  localparam logic [16:0] SRC_LAST = 17'(SRC_N - 1);
  localparam logic [16:0] DST_LAST = 17'(DST_N - 1);
  localparam logic [16:0] DST_END  = 17'(DST_N);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t      state, state_nx;
  logic [16:0] cnt;
  logic        pend;
  logic [16:0] pend_addr;
  logic [7:0]  src_mem [SRC_N];
  logic [7:0]  dst_mem [DST_N];
  logic        in_fire, out_fire, commit, drain_load, last_out;
  logic        rd_oob, wr_oob;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{rd_addr, wr_addr};

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign busy       = (state != IDLE);
  assign commit     = pend & (state == RUN);
  assign drain_load = (state == DRAIN) && (cnt != DST_END) && (!out_valid || out_ready);
  assign last_out   = (state == DRAIN) && out_fire && (cnt == DST_END);

`ifdef FRAME_MEM_RANGE_CHK_EN
  logic err_q;
  assign rd_oob = (rd_addr >= 20'(SRC_N));
  assign wr_oob = (wr_addr >= 20'(DST_N));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else if ((rd_en && rd_oob) || (wr_en && wr_oob && state == RUN)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign rd_oob = 1'b0;
  assign wr_oob = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_fire) state_nx = LOAD;
      LOAD:    if (in_fire && cnt == SRC_LAST) state_nx = RUN;
      RUN:     if (commit && cnt == DST_LAST) state_nx = DRAIN;
      DRAIN:   if (last_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memories are deliberately left out of reset; pend gates every destination write.
  always_ff @(posedge clk) begin
    if (in_fire) src_mem[cnt[SA-1:0]] <= in_data;
    if (commit)  dst_mem[pend_addr[DA-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      pend_addr  <= '0;
      in_ready   <= 1'b0;
      ena        <= 1'b0;
      frame_done <= 1'b0;
      rd_data    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state <= state_nx;
      // One counter serves as load pointer, commit count and drain pointer.
      // Pixel 0 is written in IDLE, so LOAD starts at 1.
      if (state_nx != state)                   cnt <= (state == IDLE) ? 17'd1 : 17'd0;
      else if (in_fire || commit || drain_load) cnt <= cnt + 17'd1;
      in_ready   <= (state_nx == IDLE) || (state_nx == LOAD);
      ena        <= (state_nx == RUN) && (state != RUN);
      frame_done <= last_out;
      pend       <= wr_en && !wr_oob && (state == RUN) && (state_nx == RUN);
      if (wr_en) pend_addr <= wr_addr[16:0];
      if (rd_en) rd_data <= rd_oob ? 8'h00 : src_mem[rd_addr[SA-1:0]];
      if (drain_load) begin
        out_data  <= dst_mem[cnt[DA-1:0]];
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_mem_responder.sv
// Randomized self-checking bench for frame_mem_responder on a reduced frame size.
// Reference model: plain arrays for both frames, write log applied in issue order.
module tb_frame_mem_responder;

  localparam int SW = 32;
  localparam int SH = 16;
  localparam int DW = 12;
  localparam int DH = 10;
  localparam int SN = SW * SH;
  localparam int DN = DW * DH;

  logic        clk, rstn;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        rd_en;
  logic [19:0] rd_addr;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        ena, busy, frame_done, err;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;

  frame_mem_responder #(.SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ena(ena), .busy(busy), .frame_done(frame_done), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] src_model [SN];
  logic [7:0] dst_model [DN];
  int         wq_addr [$];
  logic [7:0] wq_data [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_frame(input bit rnd_data, input bit gaps, input bit noise);
    int i, guard, ena_early;
    logic [7:0] d;
    i = 0; guard = 0; ena_early = 0;
    while (i < SN && guard < 8 * SN) begin
      in_valid = !(gaps && $urandom_range(0, 2) == 0);
      d        = rnd_data ? 8'($urandom) : 8'(i);
      in_data  = d;
      wr_en    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr  = 20'd0;
      wr_data  = 8'hC3;
      if (i == SN / 2) chk("busy_load", busy, 1);
      if (in_valid && in_ready) begin
        src_model[i] = d;
        i++;
      end
      if (ena) ena_early++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    wr_en    = 1'b0;
    chk("load_count", i, SN);
    chk("ena_early", ena_early, 0);
    chk("ena_pulse", ena, 1);
    chk("busy_run", busy, 1);
    chk("in_ready_run", in_ready, 0);
    tick();
    chk("ena_once", ena, 0);
  endtask

  task automatic rand_reads(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a = $urandom_range(0, SN - 1);
      rd_en = 1'b1; rd_addr = 20'(a);
      tick();
      rd_en = 1'b0;
      chk("rd_rand", rd_data, src_model[a]);
    end
  endtask

  task automatic shuffle_queue();
    int j, ta;
    logic [7:0] td;
    for (int k = wq_addr.size() - 1; k > 2; k--) begin
      j = $urandom_range(2, k);
      ta = wq_addr[k]; wq_addr[k] = wq_addr[j]; wq_addr[j] = ta;
      td = wq_data[k]; wq_data[k] = wq_data[j]; wq_data[j] = td;
    end
  endtask

  task automatic run_writes(input bit gaps);
    int i, guard, early;
    bit have;
    logic [7:0] d_next;
    i = 0; guard = 0; early = 0; have = 0; d_next = '0;
    while ((i < wq_addr.size() || have) && guard < 10 * DN) begin
      wr_data = have ? d_next : 8'($urandom);
      have    = 0;
      if (i < wq_addr.size() && !(gaps && i >= 2 && $urandom_range(0, 3) == 0)) begin
        wr_en   = 1'b1;
        wr_addr = 20'(wq_addr[i]);
        d_next  = wq_data[i];
        have    = 1;
        dst_model[wq_addr[i]] = wq_data[i];
        i++;
      end else begin
        wr_en   = 1'b0;
        wr_addr = 20'($urandom);
      end
      if (out_valid) early++;
      tick();
      guard++;
    end
    wr_en = 1'b0;
    chk("writes_issued", i, wq_addr.size());
    chk("drain_early", early, 0);
  endtask

  task automatic drain_frame(input bit rnd);
    int idx, fd, k, bubbles;
    bit hold;
    logic [7:0] hd;
    idx = 0; fd = 0; bubbles = 0; hold = 0; hd = '0;
    for (k = 0; k < 4 && !out_valid; k++) tick();
    chk("drain_start", out_valid && (k <= 2), 1);
    for (int c = 0; c < 6 * DN && idx < DN; c++) begin
      if (frame_done) fd++;
      if (!out_valid) bubbles++;
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
      end
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : (c % 2 == 0);
      if (out_valid && out_ready) begin
        chk("drain_px", out_data, dst_model[idx]);
        idx++;
      end
      hold = out_valid && !out_ready;
      hd   = out_data;
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", idx, DN);
    chk("drain_bubbles", bubbles, 0);
    chk("fd_early", fd, 0);
    chk("frame_done", frame_done, 1);
    chk("busy_idle", busy, 0);
    tick();
    chk("fd_pulse", frame_done, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ena", ena, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_out_data", out_data, 0);
    rstn = 1'b1;
    chk("rel_in_ready0", in_ready, 0);
    tick();
    chk("rel_in_ready1", in_ready, 1);

    // Frame 1: ramp data, fixed writes at 5/6 then every other address once
    load_frame(1'b0, 1'b0, 1'b0);
    rd_en = 1'b1; rd_addr = 20'd321;
    tick();
    chk("rd_321", rd_data, 8'h41);
    rd_en = 1'b0; rd_addr = 20'($urandom_range(0, SN - 1));
    tick();
    chk("rd_hold", rd_data, 8'h41);
    rand_reads(6);
    wq_addr.delete(); wq_data.delete();
    wq_addr.push_back(5); wq_data.push_back(8'hAA);
    wq_addr.push_back(6); wq_data.push_back(8'hBB);
    for (int a = 0; a < DN; a++) begin
      if (a == 5 || a == 6) continue;
      wq_addr.push_back(a);
      wq_data.push_back((a == 0) ? 8'h33 : 8'($urandom));
    end
    shuffle_queue();
    run_writes(1'b1);
    drain_frame(1'b0);
    chk("err_clean", err, 0);
    rand_reads(4);

    // Frame 2: random load, a few writes, then reset with a write pending to address 0
    load_frame(1'b1, 1'b1, 1'b1);
    rand_reads(6);
    wq_addr.delete(); wq_data.delete();
    for (int a = 1; a <= 3; a++) begin
      wq_addr.push_back(a); wq_data.push_back(8'($urandom));
    end
    run_writes(1'b0);
    wr_en = 1'b1; wr_addr = 20'd0;
    tick();
    wr_en = 1'b0; wr_data = 8'h5A; rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_busy", busy, 0);

    // Frame 3: address 0 is never rewritten, so it must still hold frame 1's value
    load_frame(1'b1, 1'b1, 1'b1);
    wq_addr.delete(); wq_data.delete();
    wq_addr.push_back(1); wq_data.push_back(8'($urandom));
    wq_addr.push_back(2); wq_data.push_back(8'($urandom));
    for (int a = 3; a < DN; a++) begin
      wq_addr.push_back(a); wq_data.push_back(8'($urandom));
    end
    wq_addr.push_back($urandom_range(1, DN - 1)); wq_data.push_back(8'($urandom));
    shuffle_queue();
    run_writes(1'b1);
    chk("model_addr0", dst_model[0], 8'h33);
    drain_frame(1'b1);

    rd_en = 1'b1; rd_addr = 20'(SN);
    tick();
    rd_en = 1'b0;
`ifdef FRAME_MEM_RANGE_CHK_EN
    chk("oob_rd_data", rd_data, 0);
    chk("oob_err", err, 1);
    repeat (3) tick();
    chk("oob_err_sticky", err, 1);
`else
    repeat (3) tick();
    chk("oob_err_zero", err, 0);
`endif
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("final_err", err, 0);
    chk("final_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
